fir_tap_sequencer: RTL and testbench

- Controller for the time-multiplexed FIR / moving-average datapath: one shared MAC, one circular sample buffer, one two-bank coefficient ROM.
- On each accepted input sample it writes the sample into the buffer, steps the MAC through all taps, waits out the MAC pipeline and pulses out_valid.
- Also owns coefficient-bank selection from the board toggle button; coef_bank drives LEDG at top level.

---
 rtl/fir_tap_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - tap sequencer for a time-multiplexed FIR with a shared MAC
module fir_tap_sequencer #(
    parameter int TAPS    = 8,
    parameter int ADDR_W  = 3,
    parameter int MAC_LAT = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              toggle_btn,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   coef_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              out_valid,
    output logic              out_primed,
    output logic              coef_bank,
    output logic              busy
);

    localparam int DW         = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam int DRAIN_LAST = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;
    localparam int CW         = ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, WRITE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tap_q, tap_d, tap_next;
    logic [DW-1:0]     drain_q, drain_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     prime_cnt_q, prime_cnt_d;
    logic              bank_pending_q, bank_pending_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, btn_prev_q, btn_prev_d;
    logic              sample_ready_q, sample_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   coef_addr_q, coef_addr_d;
    logic              mac_clr_q, mac_clr_d;
    logic              mac_en_q, mac_en_d;
    logic              out_valid_q, out_valid_d;
    logic              out_primed_q, out_primed_d;
    logic              coef_bank_q, coef_bank_d;
    logic              busy_q, busy_d;
    logic              accept, btn_rise, enter_done;

    always_comb begin
        state_d        = state_q;
        tap_d          = tap_q;
        drain_d        = drain_q;
        wr_ptr_d       = wr_ptr_q;
        prime_cnt_d    = prime_cnt_q;
        wr_addr_d      = wr_addr_q;
        rd_addr_d      = rd_addr_q;
        coef_addr_d    = coef_addr_q;
        wr_en_d        = 1'b0;
        mac_en_d       = 1'b0;
        mac_clr_d      = 1'b0;
        out_valid_d    = 1'b0;
        out_primed_d   = out_primed_q;
        enter_done     = 1'b0;
        tap_next       = tap_q + ADDR_W'(1);

        accept         = (state_q == IDLE) && sample_valid;
        btn_rise       = sync2_q && !btn_prev_q;
        sync1_d        = toggle_btn;
        sync2_d        = sync1_q;
        btn_prev_d     = sync2_q;
        // An edge arriving on the accept edge survives for the next sample.
        bank_pending_d = (bank_pending_q && !accept) || btn_rise;
        coef_bank_d    = coef_bank_q ^ (accept && bank_pending_q);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_ptr_q;
                end
            end
            WRITE: begin
                state_d     = RUN;
                tap_d       = '0;
                mac_en_d    = 1'b1;
                mac_clr_d   = 1'b1;
                rd_addr_d   = wr_ptr_q;
                coef_addr_d = {coef_bank_q, {ADDR_W{1'b0}}};
            end
            RUN: begin
                if (&tap_q) begin
                    if (MAC_LAT == 0) begin
                        enter_done = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end else begin
                    tap_d       = tap_next;
                    mac_en_d    = 1'b1;
                    rd_addr_d   = wr_ptr_q - tap_next;
                    coef_addr_d = {coef_bank_q, tap_next};
                end
            end
            DRAIN: begin
                if (drain_q == DW'(DRAIN_LAST)) begin
                    enter_done = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            default: state_d = IDLE;
        endcase

        if (enter_done) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            if (prime_cnt_q != CW'(TAPS)) begin
                prime_cnt_d = prime_cnt_q + CW'(1);
            end
            out_primed_d = out_primed_q || (prime_cnt_d == CW'(TAPS));
        end

        sample_ready_d = (state_d == IDLE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            tap_q          <= '0;
            drain_q        <= '0;
            wr_ptr_q       <= '0;
            prime_cnt_q    <= '0;
            bank_pending_q <= 1'b0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            btn_prev_q     <= 1'b0;
            sample_ready_q <= 1'b1;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            coef_addr_q    <= '0;
            mac_clr_q      <= 1'b0;
            mac_en_q       <= 1'b0;
            out_valid_q    <= 1'b0;
            out_primed_q   <= 1'b0;
            coef_bank_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tap_q          <= tap_d;
            drain_q        <= drain_d;
            wr_ptr_q       <= wr_ptr_d;
            prime_cnt_q    <= prime_cnt_d;
            bank_pending_q <= bank_pending_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            btn_prev_q     <= btn_prev_d;
            sample_ready_q <= sample_ready_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            coef_addr_q    <= coef_addr_d;
            mac_clr_q      <= mac_clr_d;
            mac_en_q       <= mac_en_d;
            out_valid_q    <= out_valid_d;
            out_primed_q   <= out_primed_d;
            coef_bank_q    <= coef_bank_d;
            busy_q         <= busy_d;
        end
    end

    assign sample_ready = sample_ready_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign rd_addr      = rd_addr_q;
    assign coef_addr    = coef_addr_q;
    assign mac_clr      = mac_clr_q;
    assign mac_en       = mac_en_q;
    assign out_valid    = out_valid_q;
    assign out_primed   = out_primed_q;
    assign coef_bank    = coef_bank_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - self-checking bench for fir_tap_sequencer
module tb_fir_tap_sequencer;

    localparam int TAPS    = 8;
    localparam int ADDR_W  = 3;
    localparam int MAC_LAT = 1;
    localparam int LAST    = TAPS + 2 + MAC_LAT;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              sample_valid = 1'b0;
    logic              toggle_btn = 1'b0;
    logic              sample_ready, wr_en, mac_clr, mac_en, out_valid, out_primed, coef_bank, busy;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [ADDR_W:0]   coef_addr;

    int checks = 0;
    int errors = 0;

    fir_tap_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .toggle_btn(toggle_btn), .wr_en(wr_en),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .coef_addr(coef_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .out_valid(out_valid),
        .out_primed(out_primed), .coef_bank(coef_bank), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: position within a sample's timeline plus bookkeeping values.
    int m_t, m_wrptr, m_done, m_bank, m_pend, h1, h2, h3;
    int m_wr_addr, m_rd_addr, m_coef_addr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic v, input logic tg, input logic rn);
        int k;
        logic rise;
        if (!rn) begin
            m_t = 0; m_wrptr = 0; m_done = 0; m_bank = 0; m_pend = 0;
            h1 = 0; h2 = 0; h3 = 0;
            m_wr_addr = 0; m_rd_addr = 0; m_coef_addr = 0;
        end else begin
            rise = (h2 == 1) && (h3 == 0);
            h3 = h2; h2 = h1; h1 = int'(tg);
            if (m_t == 0) begin
                if (v) begin
                    m_bank = m_bank ^ m_pend;
                    m_pend = 0;
                    m_t = 1;
                end
            end else if (m_t == LAST) begin
                m_t = 0;
                m_wrptr = (m_wrptr + 1) % TAPS;
            end else begin
                m_t++;
            end
            if (rise) m_pend = 1;
            if (m_t == LAST) m_done++;
            if (m_t == 1) m_wr_addr = m_wrptr;
            if (m_t >= 2 && m_t <= TAPS + 1) begin
                k = m_t - 2;
                m_rd_addr = (m_wrptr - k + TAPS) % TAPS;
                m_coef_addr = m_bank * TAPS + k;
            end
        end
    endtask

    task automatic compare_all();
        chk("sample_ready", int'(sample_ready), int'(m_t == 0));
        chk("busy",         int'(busy),         int'(m_t != 0));
        chk("wr_en",        int'(wr_en),        int'(m_t == 1));
        chk("wr_addr",      int'(wr_addr),      m_wr_addr);
        chk("mac_en",       int'(mac_en),       int'(m_t >= 2 && m_t <= TAPS + 1));
        chk("mac_clr",      int'(mac_clr),      int'(m_t == 2));
        chk("rd_addr",      int'(rd_addr),      m_rd_addr);
        chk("coef_addr",    int'(coef_addr),    m_coef_addr);
        chk("out_valid",    int'(out_valid),    int'(m_t == LAST));
        chk("out_primed",   int'(out_primed),   int'(m_done >= TAPS));
        chk("coef_bank",    int'(coef_bank),    m_bank);
    endtask

    task automatic cyc(input logic v, input logic tg, input logic rn);
        sample_valid = v;
        toggle_btn   = tg;
        reset_n      = rn;
        @(posedge clk);
        model_step(v, tg, rn);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    // One sample from accept to the IDLE cycle after DONE; optional 2-cycle toggle pulse.
    task automatic one_sample(input int exp_bank, input int tog_at);
        cyc(1'b1, 1'b0, 1'b1);
        for (int c = 2; c <= LAST + 1; c++) begin
            cyc(1'b0, (c == tog_at || c == tog_at + 1), 1'b1);
            if (mac_en) chk("bank_msb", int'(coef_addr[ADDR_W]), exp_bank);
        end
        chk("sample_end_ready", int'(sample_ready), 1);
    endtask

    typedef struct {
        logic v;
        logic e_wr_en;
        int   e_wr_addr;
        logic e_mac_en;
        logic e_mac_clr;
        int   e_rd_addr;
        logic e_out_valid;
        logic e_ready;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n_wr, n_ov, last_wr;

        //           v   wr  wa  me  mc  ra  ov  rdy
        tbl[0]  = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 7, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 6, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 5, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 4, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 3, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1, 1'b0, 1'b1};

        // Reset state and single-sample timeline
        do_reset();
        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bank", int'(coef_bank), 0);
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].v, 1'b0, 1'b1);
            chk("tbl_wr_en",     int'(wr_en),        int'(tbl[i].e_wr_en));
            chk("tbl_wr_addr",   int'(wr_addr),      tbl[i].e_wr_addr);
            chk("tbl_mac_en",    int'(mac_en),       int'(tbl[i].e_mac_en));
            chk("tbl_mac_clr",   int'(mac_clr),      int'(tbl[i].e_mac_clr));
            chk("tbl_rd_addr",   int'(rd_addr),      tbl[i].e_rd_addr);
            chk("tbl_out_valid", int'(out_valid),    int'(tbl[i].e_out_valid));
            chk("tbl_ready",     int'(sample_ready), int'(tbl[i].e_ready));
        end

        // Ten back-to-back samples with sample_valid held
        do_reset();
        n_wr = 0; n_ov = 0; last_wr = 0;
        for (int c = 1; c <= 120; c++) begin
            cyc(1'b1, 1'b0, 1'b1);
            if (wr_en) begin
                chk("b2b_wr_addr", int'(wr_addr), n_wr % TAPS);
                if (n_wr > 0) chk("b2b_period", c - last_wr, LAST + 1);
                last_wr = c;
                n_wr++;
            end
            if (out_valid) n_ov++;
            chk("b2b_primed", int'(out_primed), int'(n_ov >= TAPS));
        end
        chk("b2b_accepts", n_wr, 10);
        chk("b2b_results", n_ov, 10);

        // Toggle during RUN of sample 1: applies only to sample 2 onward, one flip
        do_reset();
        one_sample(0, 3);
        one_sample(1, -1);
        one_sample(1, -1);
        chk("run_toggle_bank", int'(coef_bank), 1);

        // Three pulses while idle give a single flip
        do_reset();
        for (int p = 0; p < 3; p++) begin
            cyc(1'b0, 1'b1, 1'b1);
            cyc(1'b0, 1'b1, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
        one_sample(1, -1);
        one_sample(1, -1);
        chk("idle_toggle_bank", int'(coef_bank), 1);

        // Reset during RUN at tap 4 abandons the result and clears state
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("pre_rst_tap", int'(rd_addr), (2 - 4 + TAPS) % TAPS);
        cyc(1'b0, 1'b0, 1'b0);
        chk("midrst_ready", int'(sample_ready), 1);
        chk("midrst_mac_en", int'(mac_en), 0);
        chk("midrst_bank", int'(coef_bank), 0);
        chk("midrst_primed", int'(out_primed), 0);
        n_ov = 0;
        for (int i = 0; i < LAST + 2; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (out_valid) n_ov++;
        end
        chk("midrst_no_valid", n_ov, 0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("midrst_wr_ptr", int'(wr_addr), 0);
        chk("midrst_wr_en", int'(wr_en), 1);

        // sample_valid during RUN is ignored
        n_wr = 0;
        for (int c = 2; c <= LAST + 1; c++) begin
            cyc((c >= 4 && c <= 7), 1'b0, 1'b1);
            if (wr_en) n_wr++;
        end
        chk("busy_valid_ignored", n_wr, 0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("next_accept_wr_en", int'(wr_en), 1);
        chk("next_accept_addr", int'(wr_addr), 1);

        // Randomized traffic against the reference model
        begin
            logic tg;
            tg = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 7) == 0) tg = ~tg;
                cyc(($urandom_range(0, 2) != 0), tg, ($urandom_range(0, 299) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
